// File: rtl/timer_intr_gen.sv
// Memory-mapped 64-bit machine timer with compare-match interrupt pulse.
// Optional tick prescaler is built when TIMER_PRESCALER_EN is defined.
module timer_intr_gen #(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cs,
    input  logic          we,
    input  logic [4:0]    addr_i,
    input  logic [3:0]    mask,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          t_intr
);

    localparam logic [2:0] A_MTIME_LO = 3'd0;
    localparam logic [2:0] A_MTIME_HI = 3'd1;
    localparam logic [2:0] A_CMP_LO   = 3'd2;
    localparam logic [2:0] A_CMP_HI   = 3'd3;
    localparam logic [2:0] A_CTRL     = 3'd4;
    localparam logic [2:0] A_STATUS   = 3'd5;
    localparam logic [2:0] A_PRESCALE = 3'd6;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] cur,
        input logic [31:0] wd,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? wd[8*i +: 8] : cur[8*i +: 8];
        end
        return res;
    endfunction

    logic [2:0]  sel;
    logic [31:0] wd;
    logic        unused_addr;

    assign sel         = addr_i[4:2];
    assign wd          = wdata_i;
    assign unused_addr = ^addr_i[1:0];

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        pend_q, pend_d;
    logic        match_q, match_d;
    logic        t_intr_q, t_intr_d;

    logic        wr;
    logic        wr_mtime_lo, wr_mtime_hi;
    logic        wr_cmp_lo, wr_cmp_hi;
    logic        wr_ctrl, wr_status, wr_prescale;
    logic        en, irq_en;
    logic        tick;
    logic        match, match_evt;
    logic        pend_clr;
    logic [15:0] prescale_rd;

    assign wr          = cs && we;
    assign wr_mtime_lo = wr && (sel == A_MTIME_LO);
    assign wr_mtime_hi = wr && (sel == A_MTIME_HI);
    assign wr_cmp_lo   = wr && (sel == A_CMP_LO);
    assign wr_cmp_hi   = wr && (sel == A_CMP_HI);
    assign wr_ctrl     = wr && (sel == A_CTRL);
    assign wr_status   = wr && (sel == A_STATUS);
    assign wr_prescale = wr && (sel == A_PRESCALE);

    assign en     = ctrl_q[0];
    assign irq_en = ctrl_q[1];

`ifdef TIMER_PRESCALER_EN
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] presc_cnt_q, presc_cnt_d;
    logic        en_rise;

    assign en_rise = wr_ctrl && mask[0] && wd[0] && !en;

    always_comb begin
        prescale_d = prescale_q;
        if (wr_prescale) begin
            prescale_d = merge_bytes({16'h0, prescale_q}, wd,
                                     {2'b00, mask[1:0]})[15:0];
        end
    end

    // Reload on a new divisor or on enable so the first period is full length.
    always_comb begin
        presc_cnt_d = presc_cnt_q;
        if (wr_prescale || en_rise) begin
            presc_cnt_d = prescale_d;
        end else if (en) begin
            presc_cnt_d = (presc_cnt_q == 16'h0) ? prescale_q
                                                 : presc_cnt_q - 16'd1;
        end
    end

    assign tick        = en && (presc_cnt_q == 16'h0);
    assign prescale_rd = prescale_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prescale_q  <= 16'h0;
            presc_cnt_q <= 16'h0;
        end else begin
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
        end
    end
`else
    logic unused_prescale;

    assign unused_prescale = wr_prescale;
    assign tick            = en;
    assign prescale_rd     = 16'h0;
`endif

    // Bus writes to either half win over the increment; no carry that cycle.
    always_comb begin
        mtime_d = mtime_q;
        if (wr_mtime_lo || wr_mtime_hi) begin
            if (wr_mtime_lo) begin
                mtime_d[31:0] = merge_bytes(mtime_q[31:0], wd, mask);
            end
            if (wr_mtime_hi) begin
                mtime_d[63:32] = merge_bytes(mtime_q[63:32], wd, mask);
            end
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    always_comb begin
        cmp_d = cmp_q;
        if (wr_cmp_lo) begin
            cmp_d[31:0] = merge_bytes(cmp_q[31:0], wd, mask);
        end
        if (wr_cmp_hi) begin
            cmp_d[63:32] = merge_bytes(cmp_q[63:32], wd, mask);
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_ctrl && mask[0]) begin
            ctrl_d = wd[1:0];
        end
    end

    assign match     = en && (mtime_q >= cmp_q);
    assign match_evt = match && !match_q;
    assign match_d   = match;
    assign pend_clr  = wr_status && mask[0] && wd[0];

    always_comb begin
        pend_d = pend_q;
        if (pend_clr) begin
            pend_d = 1'b0;
        end
        if (match_evt) begin
            pend_d = 1'b1;
        end
    end

    assign t_intr_d = irq_en && pend_d && !pend_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q  <= 64'h0;
            cmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
            ctrl_q   <= 2'b00;
            pend_q   <= 1'b0;
            match_q  <= 1'b0;
            t_intr_q <= 1'b0;
        end else begin
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            ctrl_q   <= ctrl_d;
            pend_q   <= pend_d;
            match_q  <= match_d;
            t_intr_q <= t_intr_d;
        end
    end

    assign t_intr = t_intr_q;

    always_comb begin
        rdata_o = '0;
        if (cs && !we) begin
            case (sel)
                A_MTIME_LO: rdata_o = mtime_q[31:0];
                A_MTIME_HI: rdata_o = mtime_q[63:32];
                A_CMP_LO:   rdata_o = cmp_q[31:0];
                A_CMP_HI:   rdata_o = cmp_q[63:32];
                A_CTRL:     rdata_o = {30'h0, ctrl_q};
                A_STATUS:   rdata_o = {31'h0, pend_q};
                A_PRESCALE: rdata_o = {16'h0, prescale_rd};
                default:    rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_intr_gen.sv
// Directed testbench for timer_intr_gen; inputs change on the falling edge
// and outputs are sampled away from the rising edge.
module tb_timer_intr_gen;

    localparam logic [4:0] A_MTIME_LO = 5'h00;
    localparam logic [4:0] A_MTIME_HI = 5'h04;
    localparam logic [4:0] A_CMP_LO   = 5'h08;
    localparam logic [4:0] A_CMP_HI   = 5'h0C;
    localparam logic [4:0] A_CTRL     = 5'h10;
    localparam logic [4:0] A_STATUS   = 5'h14;
    localparam logic [4:0] A_PRESCALE = 5'h18;
    localparam logic [4:0] A_UNMAP    = 5'h1C;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr_i = '0;
    logic [3:0]  mask = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        t_intr;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int consec = 0;
    logic prev_t = 1'b0;

    timer_intr_gen #(.DW(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cs(cs), .we(we), .addr_i(addr_i),
        .mask(mask), .wdata_i(wdata_i), .rdata_o(rdata_o), .t_intr(t_intr)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (t_intr === 1'b1) pulses++;
        if (t_intr === 1'b1 && prev_t === 1'b1) consec++;
        prev_t = t_intr;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] m);
        cs = 1'b1; we = 1'b1; addr_i = a; wdata_i = d; mask = m;
        @(negedge clk_i);
        cs = 1'b0; we = 1'b0; mask = 4'h0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cs = 1'b1; we = 1'b0; addr_i = a;
        #1;
        d = rdata_o;
        cs = 1'b0;
    endtask

    task automatic do_reset();
        cs = 1'b0; we = 1'b0;
        rst_i = 1'b1;
        idle(2);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        tests++; if (t_intr !== 1'b0) begin fails++; $display("FAIL rst_tintr got %b want 0", t_intr); end
        rd(A_MTIME_LO, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL rst_mtime_lo got %h want 0", v); end
        rd(A_MTIME_HI, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL rst_mtime_hi got %h want 0", v); end
        rd(A_CMP_LO, v);
        tests++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rst_cmp_lo got %h want ffffffff", v); end
        rd(A_CMP_HI, v);
        tests++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rst_cmp_hi got %h want ffffffff", v); end
        rd(A_CTRL, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL rst_ctrl got %h want 0", v); end
        rd(A_STATUS, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL rst_status got %h want 0", v); end
        rd(A_PRESCALE, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL rst_prescale got %h want 0", v); end
    endtask

    task automatic test_basic_match();
        logic [31:0] v;
        int p0;
        do_reset();
        p0 = pulses;
        wr(A_CMP_LO, 32'd5, 4'hF);
        wr(A_CMP_HI, 32'd0, 4'hF);
        wr(A_CTRL, 32'd3, 4'hF);
        idle(5);
        rd(A_MTIME_LO, v);
        tests++; if (v !== 32'd5) begin fails++; $display("FAIL basic_mtime got %0d want 5", v); end
        tests++; if (t_intr !== 1'b0) begin fails++; $display("FAIL basic_tintr_early got %b want 0", t_intr); end
        idle(1);
        tests++; if (t_intr !== 1'b1) begin fails++; $display("FAIL basic_tintr got %b want 1", t_intr); end
        rd(A_STATUS, v);
        tests++; if (v !== 32'd1) begin fails++; $display("FAIL basic_status got %h want 1", v); end
        idle(1);
        tests++; if (t_intr !== 1'b0) begin fails++; $display("FAIL basic_tintr_drop got %b want 0", t_intr); end
        idle(5);
        tests++; if (pulses - p0 !== 1) begin fails++; $display("FAIL basic_pulses got %0d want 1", pulses - p0); end
    endtask

    task automatic test_w1c();
        logic [31:0] v, m0;
        int p0;
        p0 = pulses;
        wr(A_CTRL, 32'd2, 4'hF);
        rd(A_STATUS, v);
        tests++; if (v !== 32'd1) begin fails++; $display("FAIL en_off_pend_hold got %h want 1", v); end
        rd(A_MTIME_LO, m0);
        idle(2);
        rd(A_MTIME_LO, v);
        tests++; if (v !== m0) begin fails++; $display("FAIL en_off_freeze got %h want %h", v, m0); end
        wr(A_CTRL, 32'd3, 4'hF);
        wr(A_STATUS, 32'd1, 4'h1);
        rd(A_STATUS, v);
        tests++; if (v !== 32'd1) begin fails++; $display("FAIL w1c_set_wins got %h want 1", v); end
        wr(A_STATUS, 32'd1, 4'h1);
        rd(A_STATUS, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL w1c_clear got %h want 0", v); end
        idle(3);
        tests++; if (pulses - p0 !== 0) begin fails++; $display("FAIL w1c_pulses got %0d want 0", pulses - p0); end
    endtask

    task automatic test_carry();
        logic [31:0] lo, hi;
        do_reset();
        wr(A_MTIME_LO, 32'hFFFF_FFFF, 4'hF);
        wr(A_MTIME_HI, 32'h0, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        idle(1);
        rd(A_MTIME_HI, hi);
        rd(A_MTIME_LO, lo);
        tests++; if (hi !== 32'd1) begin fails++; $display("FAIL carry_hi got %h want 1", hi); end
        tests++; if (lo !== 32'd0) begin fails++; $display("FAIL carry_lo got %h want 0", lo); end
        wr(A_CTRL, 32'd0, 4'hF);
        wr(A_MTIME_LO, 32'hFFFF_FFFF, 4'hF);
        wr(A_MTIME_HI, 32'h0, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        wr(A_MTIME_LO, 32'h1234_5678, 4'hF);
        rd(A_MTIME_HI, hi);
        rd(A_MTIME_LO, lo);
        tests++; if (hi !== 32'd0) begin fails++; $display("FAIL carry_wr_hi got %h want 0", hi); end
        tests++; if (lo !== 32'h1234_5678) begin fails++; $display("FAIL carry_wr_lo got %h want 12345678", lo); end
    endtask

    task automatic test_bytes();
        logic [31:0] v;
        do_reset();
        wr(A_CMP_LO, 32'h0, 4'hF);
        wr(A_CMP_LO, 32'h0000_AB00, 4'b0010);
        rd(A_CMP_LO, v);
        tests++; if (v !== 32'h0000_AB00) begin fails++; $display("FAIL byte_cmp got %h want 0000ab00", v); end
        wr(A_CMP_LO, 32'h1122_3344, 4'b1001);
        rd(A_CMP_LO, v);
        tests++; if (v !== 32'h1100_AB44) begin fails++; $display("FAIL byte_cmp2 got %h want 1100ab44", v); end
        wr(A_UNMAP, 32'hDEAD_BEEF, 4'hF);
        rd(A_UNMAP, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL unmapped got %h want 0", v); end
        wr(A_CTRL, 32'hFFFF_FFFC, 4'hF);
        rd(A_CTRL, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL ctrl_ro got %h want 0", v); end
        addr_i = A_CMP_LO; cs = 1'b0; we = 1'b0;
        #1;
        tests++; if (rdata_o !== 32'h0) begin fails++; $display("FAIL cs_low_read got %h want 0", rdata_o); end
    endtask

    task automatic test_prescale();
        logic [31:0] v;
        do_reset();
`ifdef TIMER_PRESCALER_EN
        wr(A_PRESCALE, 32'd3, 4'hF);
        rd(A_PRESCALE, v);
        tests++; if (v !== 32'd3) begin fails++; $display("FAIL presc_rd got %h want 3", v); end
        wr(A_CTRL, 32'd1, 4'hF);
        idle(3);
        rd(A_MTIME_LO, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL presc_t3 got %0d want 0", v); end
        idle(1);
        rd(A_MTIME_LO, v);
        tests++; if (v !== 32'd1) begin fails++; $display("FAIL presc_t4 got %0d want 1", v); end
        idle(4);
        rd(A_MTIME_LO, v);
        tests++; if (v !== 32'd2) begin fails++; $display("FAIL presc_t8 got %0d want 2", v); end
`else
        wr(A_PRESCALE, 32'h0000_FFFF, 4'hF);
        rd(A_PRESCALE, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL presc_absent got %h want 0", v); end
        wr(A_CTRL, 32'd1, 4'hF);
        idle(4);
        rd(A_MTIME_LO, v);
        tests++; if (v !== 32'd4) begin fails++; $display("FAIL nopresc_rate got %0d want 4", v); end
`endif
    endtask

    task automatic test_rearm();
        logic [31:0] v;
        int p0;
        do_reset();
        p0 = pulses;
        wr(A_CMP_LO, 32'd2, 4'hF);
        wr(A_CMP_HI, 32'd0, 4'hF);
        wr(A_CTRL, 32'd3, 4'hF);
        idle(6);
        tests++; if (pulses - p0 !== 1) begin fails++; $display("FAIL rearm_first got %0d want 1", pulses - p0); end
        wr(A_STATUS, 32'd1, 4'h1);
        wr(A_CMP_LO, 32'd20, 4'hF);
        rd(A_STATUS, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL rearm_cleared got %h want 0", v); end
        idle(20);
        tests++; if (pulses - p0 !== 2) begin fails++; $display("FAIL rearm_second got %0d want 2", pulses - p0); end
        rd(A_STATUS, v);
        tests++; if (v !== 32'd1) begin fails++; $display("FAIL rearm_pend got %h want 1", v); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int p0;
        do_reset();
        p0 = pulses;
        wr(A_CMP_LO, 32'd3, 4'hF);
        wr(A_CMP_HI, 32'd0, 4'hF);
        wr(A_CTRL, 32'd3, 4'hF);
        idle(3);
        rst_i = 1'b1;
        idle(1);
        tests++; if (t_intr !== 1'b0) begin fails++; $display("FAIL rmid_in_rst got %b want 0", t_intr); end
        rst_i = 1'b0;
        idle(1);
        tests++; if (t_intr !== 1'b0) begin fails++; $display("FAIL rmid_after got %b want 0", t_intr); end
        idle(4);
        tests++; if (pulses - p0 !== 0) begin fails++; $display("FAIL rmid_pulses got %0d want 0", pulses - p0); end
        rd(A_MTIME_LO, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL rmid_mtime got %h want 0", v); end
        rd(A_CMP_LO, v);
        tests++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rmid_cmp got %h want ffffffff", v); end
        rd(A_CTRL, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL rmid_ctrl got %h want 0", v); end
        rd(A_STATUS, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL rmid_status got %h want 0", v); end
    endtask

    task automatic test_back_to_back();
        tests++; if (consec !== 0) begin fails++; $display("FAIL tintr_consecutive got %0d want 0", consec); end
    endtask

    initial begin
        idle(1);
        test_reset();
        test_basic_match();
        test_w1c();
        test_carry();
        test_bytes();
        test_prescale();
        test_rearm();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
